// File: rtl/parking_meter_display.sv
// Parking-meter display driver: saturating binary-to-BCD conversion (double dabble),
// 4-digit multiplexed common-anode 7-segment output, and flash modes for low/zero time.
module parking_meter_display #(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned MAX_TIME       = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] curr_time,
  input  logic        below200,
  input  logic        isZero,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        bcd_valid
);

  localparam int unsigned REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned BLINK_W = $clog2(CLK_HZ + 1);

  localparam logic [REF_W-1:0]   REF_LAST       = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [BLINK_W-1:0] HALF_ZERO_LAST = BLINK_W'(CLK_HZ - 1);
  localparam logic [BLINK_W-1:0] HALF_LOW_LAST  = BLINK_W'(CLK_HZ / 2 - 1);
  localparam logic [15:0]        MAX_T          = 16'(MAX_TIME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    LOW    = 2'd1,
    ZERO   = 2'd2
  } mode_t;

  conv_state_t state, state_n;
  logic [15:0] bin, bin_n;
  logic [15:0] scratch, scratch_n;
  logic [15:0] adj;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [15:0] digits, digits_n;
  logic        valid_n;

  logic [REF_W-1:0] ref_cnt;
  logic [1:0]       digit_idx;

  mode_t              mode, mode_in;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] half_last;
  logic               blink_on;

  logic [3:0] sel_digit;
  logic [6:0] seg_dec;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      digits    <= '0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_n;
      bin       <= bin_n;
      scratch   <= scratch_n;
      bit_cnt   <= bit_cnt_n;
      digits    <= digits_n;
      bcd_valid <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    bin_n     = bin;
    scratch_n = scratch;
    bit_cnt_n = bit_cnt;
    digits_n  = digits;
    valid_n   = bcd_valid;
    adj       = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        bin_n     = (curr_time > MAX_T) ? MAX_T : curr_time;
        scratch_n = '0;
        bit_cnt_n = '0;
        state_n   = SHIFT;
      end
      SHIFT: begin
        scratch_n = {adj[14:0], bin[15]};
        bin_n     = {bin[14:0], 1'b0};
        bit_cnt_n = bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) state_n = LOAD;
      end
      LOAD: begin
        digits_n = scratch;
        valid_n  = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- digit refresh ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // ---------------- flash mode ----------------
  always_comb begin
    if (isZero)        mode_in = ZERO;
    else if (below200) mode_in = LOW;
    else               mode_in = NORMAL;
    half_last = (mode == ZERO) ? HALF_ZERO_LAST : HALF_LOW_LAST;
  end

  // A mode change restarts the flash cycle in the ON phase on the same edge it is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode      <= NORMAL;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (mode_in != mode) begin
      mode      <= mode_in;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (mode == NORMAL) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == half_last) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // ---------------- segment decode and output ----------------
  always_comb begin
    case (digit_idx)
      2'd0:    sel_digit = digits[3:0];
      2'd1:    sel_digit = digits[7:4];
      2'd2:    sel_digit = digits[11:8];
      default: sel_digit = digits[15:12];
    endcase
    case (sel_digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !blink_on) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= seg_dec;
    end
  end

  assign dp = 1'b1;

endmodule
